// File: rtl/uart_byte_rx.sv
// uart_byte_rx: RS-232 asynchronous byte receiver (8N1, LSB first), 16x oversampled.
// Recovers bytes from the raw rs232rx pin and presents each good byte with a
// one-cycle rxready strobe; framing errors produce a one-cycle rxerr strobe.
// Optional build macro: RX_PARITY_EN adds an even-parity bit between data and stop.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   rs232rx  in   raw serial line, asynchronous, idle high
//   rxready  out  one-cycle strobe, rxdata holds a new good byte
//   rxdata   out  last good byte, stable until the next rxready
//   rxerr    out  one-cycle strobe, framing (or parity) error
module uart_byte_rx #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232rx,
    output logic       rxready,
    output logic [7:0] rxdata,
    output logic       rxerr
);

    localparam int unsigned DIV_RAW = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic             r_sync1;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_div_cnt;
    logic             w_tick;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_smp;
    logic [3:0]       w_smp_nxt;
    logic [2:0]       r_bitcnt;
    logic [2:0]       w_bitcnt_nxt;
    logic [7:0]       r_shreg;
    logic [7:0]       w_shreg_nxt;
    logic             r_v7;
    logic             w_v7_nxt;
    logic             r_v8;
    logic             w_v8_nxt;
    logic             w_vote;
    logic             w_vpt;
    logic             w_wrap;
    logic             w_rxready_nxt;
    logic             w_rxerr_nxt;
    logic [7:0]       w_rxdata_nxt;
`ifdef RX_PARITY_EN
    logic             r_par;
    logic             w_par_nxt;
`endif

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rs232rx;
            r_rx_s  <= r_sync1;
        end
    end

    // Oversample tick; held at 0 while idle so its phase follows the start edge.
    assign w_tick = (r_div_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
        end else if (r_state == S_IDLE || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + CNT_W'(1);
        end
    end

    // Majority of the samples taken at smp 7, 8 and the live one at smp 9.
    assign w_vote = (r_v7 & r_v8) | (r_v7 & r_rx_s) | (r_v8 & r_rx_s);
    assign w_vpt  = w_tick && (r_smp == 4'd9);
    assign w_wrap = w_tick && (r_smp == 4'd15);

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_smp    <= 4'd0;
            r_bitcnt <= 3'd0;
            r_shreg  <= 8'h00;
            r_v7     <= 1'b0;
            r_v8     <= 1'b0;
            rxready  <= 1'b0;
            rxerr    <= 1'b0;
            rxdata   <= 8'h00;
`ifdef RX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_smp    <= w_smp_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shreg  <= w_shreg_nxt;
            r_v7     <= w_v7_nxt;
            r_v8     <= w_v8_nxt;
            rxready  <= w_rxready_nxt;
            rxerr    <= w_rxerr_nxt;
            rxdata   <= w_rxdata_nxt;
`ifdef RX_PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_smp_nxt     = r_smp;
        w_bitcnt_nxt  = r_bitcnt;
        w_shreg_nxt   = r_shreg;
        w_v7_nxt      = r_v7;
        w_v8_nxt      = r_v8;
        w_rxready_nxt = 1'b0;
        w_rxerr_nxt   = 1'b0;
        w_rxdata_nxt  = rxdata;
`ifdef RX_PARITY_EN
        w_par_nxt     = r_par;
`endif

        if (w_tick) begin
            w_smp_nxt = r_smp + 4'd1;
            if (r_smp == 4'd7) w_v7_nxt = r_rx_s;
            if (r_smp == 4'd8) w_v8_nxt = r_rx_s;
        end

        case (r_state)
            S_IDLE: begin
                w_smp_nxt    = 4'd0;
                w_bitcnt_nxt = 3'd0;
                if (!r_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                // A high vote means the falling edge was a glitch.
                if (w_vpt && w_vote) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wrap) begin
                    w_state_nxt  = S_DATA;
                    w_bitcnt_nxt = 3'd0;
                end
            end
            S_DATA: begin
                if (w_vpt) w_shreg_nxt = {w_vote, r_shreg[7:1]};
                if (w_wrap) begin
                    if (r_bitcnt == 3'd7) begin
`ifdef RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (w_vpt) w_par_nxt = w_vote;
                if (w_wrap) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                // Leave mid-stop-bit so an immediately following start edge is caught.
                if (w_vpt) begin
                    if (w_vote) begin
`ifdef RX_PARITY_EN
                        if ((^{r_shreg, r_par}) == 1'b0) begin
                            w_rxready_nxt = 1'b1;
                            w_rxdata_nxt  = r_shreg;
                        end else begin
                            w_rxerr_nxt = 1'b1;
                        end
`else
                        w_rxready_nxt = 1'b1;
                        w_rxdata_nxt  = r_shreg;
`endif
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_rxerr_nxt = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it reports only one error.
                w_smp_nxt = 4'd0;
                if (r_rx_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
